seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning seg and dp_out are driven active-low when 1 and active-high when 0.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port clk_display, input, 1, a single-cycle scan tick (nominally 500 Hz) that advances the digit scan.
REQ-005 The block SHALL have port clk_blink, input, 1, a single-cycle blink tick (nominally 1 Hz) that toggles the blink phase.
REQ-006 The block SHALL have port digits, input, 16, four nibbles: digit n = digits[4n+3:4n], and digit 0 is rightmost.
REQ-007 The block SHALL have port blink_mask, input, 4, where bit n=1 makes digit n blink.
REQ-008 The block SHALL have port dp, input, 4, where bit n=1 lights the decimal point of digit n.
REQ-009 The block SHALL have port an, output, 4, the registered active-low anode enables (an[n] drives digit n).
REQ-010 The block SHALL have port seg, output, 7, the registered segment drive with seg[0]=a through seg[6]=g.
REQ-011 The block SHALL have port dp_out, output, 1, the registered decimal-point drive.

Function
REQ-012 The block SHALL hold a 2-bit scan index idx; each cycle with clk_display=1 SHALL advance idx by 1 with wrap 3->0; a tick held high for k cycles SHALL count as k ticks.
REQ-013 The block SHALL hold shadow registers for digits, blink_mask and dp, loaded only on a clk_display tick while idx==3 (the wrap to 0); input changes at any other time SHALL NOT affect displayed values.
REQ-014 The block SHALL hold blink phase bit blink_on, toggled on each cycle with clk_blink=1.
REQ-015 The block SHALL update an, seg and dp_out on the same clock edge that updates idx, shadow and blink_on, computed from their post-edge values, with no extra cycle of latency.
REQ-016 Unblanked, an SHALL be one-hot low at bit idx, and all other bits SHALL be 1.
REQ-017 The decode SHALL map active-high patterns (bit 0=a) from the shadow nibble as: 0:0x3F, 1:0x06, 2:0x5B, 3:0x4F, 4:0x66, 5:0x6D, 6:0x7D, 7:0x07, 8:0x7F, 9:0x6F, 0xA:0x40 ('-'), 0xB-0xF:0x00 (blank segments, anode still enabled).
REQ-018 dp_out SHALL be the shadow dp[idx], active-high logic before polarity.
REQ-019 When blink_on=1 and shadow blink_mask[idx]=1, the block SHALL show the digit blanked: an=4'b1111, all segments off, dp off.
REQ-020 With SEG_ACTIVE_LOW=1, seg and dp_out SHALL be the bitwise inverse of the active-high values; "off" means all ones.
REQ-021 When both ticks occur in the same cycle, the block SHALL apply the idx advance, shadow load (if wrapping) and blink toggle together, and the outputs SHALL reflect all three.
REQ-022 Between ticks, the block SHALL hold all outputs stable.

Reset
REQ-023 While reset=0 at a rising edge, the block SHALL set idx=3, blink_on=0, all shadows=0, an=4'b1111, and seg and dp_out to "off"; ticks SHALL be ignored.
REQ-024 After reset deasserts, outputs SHALL stay blank until the first clk_display tick, which wraps idx to 0, loads the shadows and shows digit 0.
REQ-025 A reset asserted mid-scan or mid-blink SHALL abort immediately on that edge, with no partial update.

Verification (SEG_ACTIVE_LOW=1)
REQ-026 Reset: reset=0 for 3 cycles with both ticks pulsing -> an=4'b1111, seg=7'h7F, dp_out=1 throughout.
REQ-027 Scan: digits=16'h1234, mask=0, dp=4'b0100, then 5 clk_display ticks -> an/seg per tick: 1110/7'h19('4'), 1101/7'h30('3'), 1011/7'h24('2') with dp_out=0, 0111/7'h79('1'), then 1110/7'h19 again, each on the tick's edge.
REQ-028 No tearing: at idx=1 change digits to 16'h5678 -> digits 2,3 still show '2','1'; after the wrap, digit 0 shows '8' (seg=7'h00).
REQ-029 Blink: mask=4'b0001 at idx=0, one clk_blink tick -> an=4'b1111, seg=7'h7F; second blink tick -> digit 0 shown again; digits 1-3 unaffected.
REQ-030 Simultaneous: idx=3, blink_on=0, new mask=4'b0001, both ticks same cycle -> next edge idx=0 and the digit is blanked immediately (an=4'b1111).
REQ-031 Decode edges: nibble 0xA -> seg=7'h3F with anode active; nibble 0xC -> seg=7'h7F with anode still active.

Source files
------------

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment scanner with shadowed inputs, per-digit blink and decimal points.
// Outputs are registered and change on the same edge as the scan index; zero extra latency.
module seg_scan_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_display,
  input  logic        clk_blink,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]  idx;
  logic [15:0] sh_digits;
  logic [3:0]  sh_mask;
  logic [3:0]  sh_dp;
  logic        blink_on;
  logic        live;

  logic [1:0]  idx_nxt;
  logic        wrap;
  logic [15:0] sh_digits_nxt;
  logic [3:0]  sh_mask_nxt;
  logic [3:0]  sh_dp_nxt;
  logic        blink_nxt;
  logic        live_nxt;
  logic [3:0]  nibble;
  logic [6:0]  seg_hi;
  logic        blank;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;

  // Outputs are decoded from the post-edge state so they land on the tick's own edge.
  always_comb begin
    wrap          = clk_display && (idx == 2'd3);
    idx_nxt       = idx + 2'(clk_display);
    sh_digits_nxt = wrap ? digits : sh_digits;
    sh_mask_nxt   = wrap ? blink_mask : sh_mask;
    sh_dp_nxt     = wrap ? dp : sh_dp;
    blink_nxt     = blink_on ^ clk_blink;
    live_nxt      = live | clk_display;
    nibble        = sh_digits_nxt[{idx_nxt, 2'b00} +: 4];

    case (nibble)
      4'h0:    seg_hi = 7'h3F;
      4'h1:    seg_hi = 7'h06;
      4'h2:    seg_hi = 7'h5B;
      4'h3:    seg_hi = 7'h4F;
      4'h4:    seg_hi = 7'h66;
      4'h5:    seg_hi = 7'h6D;
      4'h6:    seg_hi = 7'h7D;
      4'h7:    seg_hi = 7'h07;
      4'h8:    seg_hi = 7'h7F;
      4'h9:    seg_hi = 7'h6F;
      4'hA:    seg_hi = 7'h40;
      default: seg_hi = 7'h00;
    endcase

    // Nothing is shown until the first scan tick after reset has loaded the shadows.
    blank = !live_nxt || (blink_nxt && sh_mask_nxt[idx_nxt]);

    if (blank) begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_OFF;
      dp_nxt  = DP_OFF;
    end else begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_nxt  = SEG_ACTIVE_LOW ? ~sh_dp_nxt[idx_nxt] : sh_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= 2'd3;
      sh_digits <= '0;
      sh_mask   <= '0;
      sh_dp     <= '0;
      blink_on  <= 1'b0;
      live      <= 1'b0;
      an        <= 4'b1111;
      seg       <= SEG_OFF;
      dp_out    <= DP_OFF;
    end else begin
      idx       <= idx_nxt;
      sh_digits <= sh_digits_nxt;
      sh_mask   <= sh_mask_nxt;
      sh_dp     <= sh_dp_nxt;
      blink_on  <= blink_nxt;
      live      <= live_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp_out    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboarded bench: directed scenarios plus random ticks/inputs against a behavioural display model.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_display;
  logic        clk_blink;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;

  seg_scan_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .clk_display(clk_display), .clk_blink(clk_blink),
    .digits(digits), .blink_mask(blink_mask), .dp(dp),
    .an(an), .seg(seg), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  // Active-high glyphs by nibble value.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Behavioural state of the display as the user would describe it.
  int         m_pos;
  bit         m_blink;
  bit         m_started;
  logic [3:0] m_digit [4];
  bit         m_flash [4];
  bit         m_point [4];

  function automatic logic [11:0] model_view();
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    if (!m_started || (m_blink && m_flash[m_pos])) begin
      a = 4'b1111; s = 7'h7F; d = 1'b1;
    end else begin
      a = 4'b1111;
      a[m_pos] = 1'b0;
      s = ~glyph[m_digit[m_pos]];
      d = ~m_point[m_pos];
    end
    return {a, s, d};
  endfunction

  task automatic step(input logic r, input logic d, input logic b,
                      input logic [15:0] dg, input logic [3:0] mk, input logic [3:0] p);
    @(negedge clk);
    reset = r; clk_display = d; clk_blink = b;
    digits = dg; blink_mask = mk; dp = p;
    if (!r) begin
      m_pos = 3; m_blink = 0; m_started = 0;
      for (int i = 0; i < 4; i++) begin
        m_digit[i] = 4'h0; m_flash[i] = 0; m_point[i] = 0;
      end
    end else begin
      if (d) begin
        if (m_pos == 3) begin
          for (int i = 0; i < 4; i++) begin
            m_digit[i] = dg[i*4 +: 4]; m_flash[i] = mk[i]; m_point[i] = p[i];
          end
        end
        m_pos = (m_pos + 1) % 4;
        m_started = 1;
      end
      if (b) m_blink = !m_blink;
    end
    exp_q.push_back(model_view());
    @(posedge clk);
    #2;
  endtask

  // Directed check against literal display values.
  task automatic chk(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    n_checks++;
    if (an !== a || seg !== s || dp_out !== d) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, an, seg, dp_out, a, s, d);
    end
  endtask

  // Monitor: every edge presents a new output word; compare against the queued model view.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg, dp_out} !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 $time, an, seg, dp_out, e[11:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    reset = 1'b0; clk_display = 1'b0; clk_blink = 1'b0;
    digits = '0; blink_mask = '0; dp = '0;

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 16'hFFFF, 4'hF, 4'hF);
      chk("reset", 4'b1111, 7'h7F, 1'b1);
    end

    step(1, 0, 0, 16'h1234, 4'b0000, 4'b0100);
    chk("post_reset_blank", 4'b1111, 7'h7F, 1'b1);
    step(1, 0, 0, 16'h1234, 4'b0000, 4'b0100);
    chk("post_reset_blank2", 4'b1111, 7'h7F, 1'b1);

    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_d0", 4'b1110, 7'h19, 1'b1);
    step(1, 0, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_hold", 4'b1110, 7'h19, 1'b1);
    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_d1", 4'b1101, 7'h30, 1'b1);
    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_d2_dp", 4'b1011, 7'h24, 1'b0);
    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_d3", 4'b0111, 7'h79, 1'b1);
    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("scan_wrap", 4'b1110, 7'h19, 1'b1);

    // Digits change mid-scan; the old frame must finish before the new one appears.
    step(1, 1, 0, 16'h1234, 4'b0000, 4'b0100); chk("tear_d1", 4'b1101, 7'h30, 1'b1);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("tear_d2", 4'b1011, 7'h24, 1'b0);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("tear_d3", 4'b0111, 7'h79, 1'b1);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("tear_new_d0", 4'b1110, 7'h00, 1'b1);

    step(1, 0, 1, 16'h5678, 4'b0001, 4'b0100); chk("blink_off", 4'b1111, 7'h7F, 1'b1);
    step(1, 0, 1, 16'h5678, 4'b0001, 4'b0100); chk("blink_on_again", 4'b1110, 7'h00, 1'b1);
    step(1, 0, 1, 16'h5678, 4'b0001, 4'b0100); chk("blink_off2", 4'b1111, 7'h7F, 1'b1);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("blink_d1_unaff", 4'b1101, 7'h78, 1'b1);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("blink_d2_unaff", 4'b1011, 7'h02, 1'b0);
    step(1, 1, 0, 16'h5678, 4'b0001, 4'b0100); chk("blink_d3_unaff", 4'b0111, 7'h12, 1'b1);
    step(1, 0, 1, 16'h5678, 4'b0001, 4'b0100); chk("blink_phase_reset", 4'b0111, 7'h12, 1'b1);

    // Both ticks together at the wrap: new mask and blink phase apply at once.
    step(1, 1, 1, 16'hC00A, 4'b0001, 4'b0000); chk("simultaneous", 4'b1111, 7'h7F, 1'b1);
    step(1, 0, 1, 16'hC00A, 4'b0001, 4'b0000); chk("dash", 4'b1110, 7'h3F, 1'b1);
    step(1, 1, 0, 16'hC00A, 4'b0001, 4'b0000); chk("zero", 4'b1101, 7'h40, 1'b1);
    step(1, 1, 0, 16'hC00A, 4'b0001, 4'b0000);
    step(1, 1, 0, 16'hC00A, 4'b0001, 4'b0000); chk("nibble_c", 4'b0111, 7'h7F, 1'b1);

    // Reset in the middle of a scan aborts everything on that edge.
    step(0, 1, 1, 16'h9999, 4'b0000, 4'b1111); chk("mid_reset", 4'b1111, 7'h7F, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic r, d, b;
      r = ($urandom_range(0, 99) != 0);
      d = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 7) == 0) begin
        digits = 16'($urandom); blink_mask = 4'($urandom); dp = 4'($urandom);
      end
      step(r, d, b, digits, blink_mask, dp);
    end

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
